// File: rtl/button_debounce_pkg.sv
// Shared constants for the button conditioner: default channel count and
// the console's named button positions within btn_raw.
package btn_pkg;

  localparam int N_BTN_DEFAULT = 8;

  localparam int BTN_UP     = 0;
  localparam int BTN_DOWN   = 1;
  localparam int BTN_LEFT   = 2;
  localparam int BTN_RIGHT  = 3;
  localparam int BTN_A      = 4;
  localparam int BTN_B      = 5;
  localparam int BTN_START  = 6;
  localparam int BTN_SELECT = 7;

endpackage

// File: rtl/button_debounce_if.sv
// Bundle between the button conditioner and its consumers; the master side
// supplies the tick enable and raw buttons, the slave side is the conditioner.
interface button_debounce_if #(
  parameter int N_BTN = btn_pkg::N_BTN_DEFAULT
);

  logic             tick;
  logic [N_BTN-1:0] btn_raw;
  logic [N_BTN-1:0] btn_state;
  logic [N_BTN-1:0] press_pulse;
  logic [N_BTN-1:0] release_pulse;
  logic [N_BTN-1:0] rep_pulse;
  logic             any_press;

  modport master (
    output tick, btn_raw,
    input  btn_state, press_pulse, release_pulse, rep_pulse, any_press
  );

  modport slave (
    input  tick, btn_raw,
    output btn_state, press_pulse, release_pulse, rep_pulse, any_press
  );

endinterface

// File: rtl/button_debounce_channel.sv
// One button channel: two-flop synchronizer, tick-gated debounce counter and
// typematic repeat counter, with all pulses registered.
module debounce_channel #(
  parameter int DB_TICKS  = 4,
  parameter int REP_DELAY = 30,
  parameter int REP_RATE  = 6,
  parameter bit REP_EN    = 1'b1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic tick_i,
  input  logic raw_i,
  output logic state_o,
  output logic press_o,
  output logic release_o,
  output logic rep_o
);

  localparam int DBW     = $clog2(DB_TICKS + 1);
  localparam int REP_MAX = (REP_DELAY > REP_RATE) ? REP_DELAY : REP_RATE;
  localparam int RW      = $clog2(REP_MAX + 1);

  localparam logic [DBW-1:0] DB_LAST   = DBW'(DB_TICKS - 1);
  localparam logic [RW-1:0]  REP_FIRST = RW'(REP_DELAY - 1);
  localparam logic [RW-1:0]  REP_NEXT  = RW'(REP_RATE - 1);

  logic           syncMeta_q;
  logic           sync_q;
  logic [DBW-1:0] dbCnt_q,   dbCnt_d;
  logic [RW-1:0]  repCnt_q,  repCnt_d;
  logic           state_q,   state_d;
  logic           press_q,   press_d;
  logic           release_q, release_d;
  logic           rep_q,     rep_d;

  // Repeat logic keys off the post-update level so a press restarts the
  // delay and a releasing tick can never emit a repeat strobe.
  always_comb begin
    dbCnt_d   = dbCnt_q;
    repCnt_d  = repCnt_q;
    state_d   = state_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    rep_d     = 1'b0;
    if (tick_i) begin
      if (sync_q == state_q) begin
        dbCnt_d = '0;
      end else if (dbCnt_q == DB_LAST) begin
        dbCnt_d   = '0;
        state_d   = sync_q;
        press_d   = sync_q;
        release_d = ~sync_q;
      end else begin
        dbCnt_d = dbCnt_q + 1'b1;
      end

      if (!REP_EN || !state_d) begin
        repCnt_d = '0;
      end else if (press_d) begin
        repCnt_d = REP_FIRST;
      end else if (repCnt_q == '0) begin
        rep_d    = 1'b1;
        repCnt_d = REP_NEXT;
      end else begin
        repCnt_d = repCnt_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      syncMeta_q <= 1'b0;
      sync_q     <= 1'b0;
      dbCnt_q    <= '0;
      repCnt_q   <= '0;
      state_q    <= 1'b0;
      press_q    <= 1'b0;
      release_q  <= 1'b0;
      rep_q      <= 1'b0;
    end else begin
      syncMeta_q <= raw_i;
      sync_q     <= syncMeta_q;
      dbCnt_q    <= dbCnt_d;
      repCnt_q   <= repCnt_d;
      state_q    <= state_d;
      press_q    <= press_d;
      release_q  <= release_d;
      rep_q      <= rep_d;
    end
  end

  assign state_o   = state_q;
  assign press_o   = press_q;
  assign release_o = release_q;
  assign rep_o     = rep_q;

endmodule

// File: rtl/button_debounce.sv
// Button conditioner top: one independent debounce_channel per button plus
// the any_press summary used to wake the menu logic.
module button_debounce
  import btn_pkg::*;
#(
  parameter int N_BTN     = N_BTN_DEFAULT,
  parameter int DB_TICKS  = 4,
  parameter int REP_DELAY = 30,
  parameter int REP_RATE  = 6,
  parameter bit REP_EN    = 1'b1
) (
  input logic               clk,
  input logic               rst,
  button_debounce_if.slave  bus
);

  logic [N_BTN-1:0] stateVec;
  logic [N_BTN-1:0] pressVec;
  logic [N_BTN-1:0] releaseVec;
  logic [N_BTN-1:0] repVec;

  for (genvar i = 0; i < N_BTN; i++) begin : g_chan
    debounce_channel #(
      .DB_TICKS  (DB_TICKS),
      .REP_DELAY (REP_DELAY),
      .REP_RATE  (REP_RATE),
      .REP_EN    (REP_EN)
    ) u_chan (
      .clk_i     (clk),
      .rst_i     (rst),
      .tick_i    (bus.tick),
      .raw_i     (bus.btn_raw[i]),
      .state_o   (stateVec[i]),
      .press_o   (pressVec[i]),
      .release_o (releaseVec[i]),
      .rep_o     (repVec[i])
    );
  end

  assign bus.btn_state     = stateVec;
  assign bus.press_pulse   = pressVec;
  assign bus.release_pulse = releaseVec;
  assign bus.rep_pulse     = repVec;
  assign bus.any_press     = |pressVec;

endmodule

// File: doc/button_debounce.md
Name: button_debounce

Overview:
- Gamepad/front-panel button conditioner for the console.
- Sits directly downstream of the slow-tick generator and uses its single-cycle tick as the sampling enable.
- Synchronises raw buttons, debounces each one over a number of ticks, and produces clean level, press/release pulses and typematic auto-repeat strobes for the game logic and menu FSMs.

Parameters:
- N_BTN, 8, number of independent button channels.
- DB_TICKS, 4, consecutive disagreeing ticks required to change a debounced level (>=1).
- REP_DELAY, 30, ticks from press to first auto-repeat strobe (>=1).
- REP_RATE, 6, ticks between subsequent auto-repeat strobes (>=1).
- REP_EN, 1, 1 = auto-repeat enabled, 0 = rep_pulse tied low.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- tick  in  1  single-clk-cycle sample enable from the slow-tick generator.
- btn_raw  in  N_BTN  asynchronous raw button inputs; 1 = pressed.
- btn_state  out  N_BTN  debounced level.
- press_pulse  out  N_BTN  one-cycle pulse on debounced 0->1.
- release_pulse  out  N_BTN  one-cycle pulse on debounced 1->0.
- rep_pulse  out  N_BTN  one-cycle pulse on each auto-repeat event.
- any_press  out  1  OR-reduction of press_pulse, same cycle.

Behaviour:
- Reset: all synchronizer flops, debounce counters, repeat counters, btn_state, press_pulse, release_pulse, rep_pulse and any_press = 0.
- Synchronizer: 2-flop chain per bit, clocked every clk (not tick-gated); sync = second stage.
- Debounce, per channel, evaluated only on cycles with tick=1:
  - If sync == btn_state: db_cnt <= 0.
  - Else, if db_cnt == DB_TICKS-1: btn_state <= sync and db_cnt <= 0.
  - Else: db_cnt <= db_cnt+1.
  - db_cnt width = $clog2(DB_TICKS+1); db_cnt never exceeds DB_TICKS-1.
- A level flips on the DB_TICKS-th consecutive disagreeing tick. A single agreeing tick restarts the count.
- Pulses are registered: press_pulse/release_pulse assert on the same clk edge that updates btn_state, high for exactly one clk cycle. Outside tick cycles, all pulses are 0.
- Latency: an input step reaches btn_state 2 clk (sync) + DB_TICKS ticks later.
- Auto-repeat (REP_EN=1), per channel:
  - On the press edge: rep_cnt <= REP_DELAY-1.
  - On each later tick while btn_state=1: if rep_cnt==0, assert rep_pulse and set rep_cnt <= REP_RATE-1; else rep_cnt <= rep_cnt-1.
  - On release, or while btn_state=0: rep_cnt held at 0 and no rep_pulse.
  - rep_cnt width = $clog2(max(REP_DELAY,REP_RATE)+1).
- First rep_pulse comes REP_DELAY ticks after press_pulse; later ones every REP_RATE ticks.
- A tick that releases the button never emits rep_pulse.
- press_pulse and rep_pulse are never high in the same cycle for one channel.
- tick held high continuously is legal: every clk then counts as a tick.
- Reset mid-operation clears everything. A button still held when rst drops produces a fresh press_pulse after 2 clk + DB_TICKS ticks.
- Channels are fully independent; simultaneous events on different channels all pulse in the same cycle.

Decomposition:
- Package btn_pkg:
  - localparam default N_BTN.
  - Named button index constants: BTN_UP, BTN_DOWN, BTN_LEFT, BTN_RIGHT, BTN_A, BTN_B, BTN_START, BTN_SELECT = 0..7.
- Sub-module debounce_channel: one channel (sync, db_cnt, rep_cnt, three pulse flops). Instantiated N_BTN times in a generate loop.
- Top level: instantiation plus the any_press reduction.

Test Plan:
- Reset/idle: rst=1 for 3 clk, btn_raw=8'hFF, tick every 4 clk -> all outputs 0 during reset. After release, btn_state=8'hFF and press_pulse=8'hFF for 1 clk on the 4th tick after sync settles; any_press=1 that cycle.
- Bounce reject: DB_TICKS=4, bit0 toggles 1,0,1,0,1,1,1,1 on successive ticks -> btn_state[0] rises only on the 4th consecutive high tick; exactly one press_pulse[0]; no release_pulse.
- Release: hold bit3 stable, then drop it for 4 ticks -> btn_state[3] falls with a single-cycle release_pulse[3]; rep_pulse[3] stays 0 thereafter.
- Auto-repeat: REP_DELAY=30, REP_RATE=6, hold bit5 for 60 ticks after press -> rep_pulse[5] at ticks 30, 36, 42, 48, 54, 60 after press_pulse, each exactly 1 clk wide.
- Continuous tick: tick tied to 1, bits 1 and 6 pressed in the same cycle -> both press_pulses in the same clk, 2+4 clk after the input step.
- Mid-operation reset: assert rst for 1 clk during bit2 repeat phase -> all outputs 0 next cycle; with bit2 still held, a new press_pulse[2] follows 4 ticks later and the first repeat comes REP_DELAY ticks after that.
